// File: rtl/nn_tt_pkg.sv
// Shared definitions for the image frame transmitter: default geometry,
// counter width and the transmit FSM state encoding.
// The CSUM state only exists when IMAGE_FRAME_TX_CHECKSUM_EN is defined.
package nn_tt_pkg;

  localparam int PIXEL_W_DEF      = 8;
  localparam int FRAME_PIXELS_DEF = 64;
  localparam int CNT_W            = 7;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_SEND = 2'd2
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
    ,
    ST_CSUM = 2'd3
`endif
  } tx_state_e;

endpackage

// File: rtl/frame_buffer_ram.sv
// Frame buffer: one write port, one registered read port.
// The read register returns zero whenever no read is requested, so its
// output can drive the transmit data bus directly and idles at zero.
module frame_buffer_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_q_r;

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port, zero when idle or in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q_r <= '0;
    end else if (rd_en) begin
      rd_q_r <= mem_r[rd_addr];
    end else begin
      rd_q_r <= '0;
    end
  end

  assign rd_data = rd_q_r;

endmodule

// File: rtl/image_frame_tx.sv
// Image frame transmitter: buffers one frame of host pixels, then streams
// it out as a contiguous burst with start/end-of-frame markers.
// Optional feature macro: IMAGE_FRAME_TX_CHECKSUM_EN appends one byte
// holding the modular sum of all frame pixels, which then carries tx_eof.
module image_frame_tx
  import nn_tt_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int PIXEL_W      = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               tx_en,
  output logic [PIXEL_W-1:0] tx_data,
  output logic               tx_valid,
  output logic               tx_sof,
  output logic               tx_eof,
  output logic               busy
);

  localparam int ADDR_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  tx_state_e          state_r, state_nxt_s;
  logic [CNT_W-1:0]   wr_cnt_r, wr_cnt_nxt_s;
  logic [CNT_W-1:0]   rd_cnt_r, rd_cnt_nxt_s;
  logic               wr_en_s, rd_en_s;
  logic               tx_valid_r, tx_valid_nxt_s;
  logic               tx_sof_r, tx_sof_nxt_s;
  logic               tx_eof_r, tx_eof_nxt_s;
  logic               in_ready_r, in_ready_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [PIXEL_W-1:0] ram_q_s;

`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
  logic [PIXEL_W-1:0] csum_r, csum_nxt_s;
  logic [PIXEL_W-1:0] csum_out_r, csum_out_nxt_s;

  // Running frame checksum: plain modular addition of pixels.
  function automatic logic [PIXEL_W-1:0] csum_add(
    input logic [PIXEL_W-1:0] sum,
    input logic [PIXEL_W-1:0] pix
  );
    return sum + pix;
  endfunction
`endif

  frame_buffer_ram #(
    .DEPTH  (FRAME_PIXELS),
    .DATA_W (PIXEL_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_cnt_r[ADDR_W-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_cnt_r[ADDR_W-1:0]),
    .rd_data (ram_q_s)
  );

  // Next-state, counter and next-output decode for the fill/send sequence.
  // rd_cnt counts bytes already requested from the buffer; when it reaches
  // FRAME_PIXELS the last pixel is on the bus and the frame closes.
  always_comb begin
    state_nxt_s    = state_r;
    wr_cnt_nxt_s   = wr_cnt_r;
    rd_cnt_nxt_s   = rd_cnt_r;
    wr_en_s        = 1'b0;
    rd_en_s        = 1'b0;
    tx_valid_nxt_s = 1'b0;
    tx_sof_nxt_s   = 1'b0;
    tx_eof_nxt_s   = 1'b0;
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
    csum_nxt_s     = csum_r;
    csum_out_nxt_s = '0;
`endif
    case (state_r)
      ST_FILL: begin
        if (in_valid && in_ready_r) begin
          wr_en_s      = 1'b1;
          wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
          csum_nxt_s   = csum_add(csum_r, in_data);
`endif
          if (wr_cnt_r == LAST_IDX) begin
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_FULL: begin
        if (tx_en) begin
          state_nxt_s    = ST_SEND;
          rd_en_s        = 1'b1;
          rd_cnt_nxt_s   = CNT_ONE;
          tx_valid_nxt_s = 1'b1;
          tx_sof_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      ST_SEND: begin
        if (rd_cnt_r < LAST_CNT) begin
          rd_en_s        = 1'b1;
          rd_cnt_nxt_s   = rd_cnt_r + CNT_ONE;
          tx_valid_nxt_s = 1'b1;
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
          tx_eof_nxt_s   = 1'b0;
`else
          tx_eof_nxt_s   = (rd_cnt_r == LAST_IDX);
`endif
        end else begin
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
          state_nxt_s    = ST_CSUM;
          tx_valid_nxt_s = 1'b1;
          tx_eof_nxt_s   = 1'b1;
          csum_out_nxt_s = csum_r;
`else
          state_nxt_s    = ST_FILL;
          wr_cnt_nxt_s   = CNT_ZERO;
          rd_cnt_nxt_s   = CNT_ZERO;
`endif
        end
      end
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
      ST_CSUM: begin
        state_nxt_s  = ST_FILL;
        wr_cnt_nxt_s = CNT_ZERO;
        rd_cnt_nxt_s = CNT_ZERO;
        csum_nxt_s   = '0;
      end
`endif
      default: begin
        state_nxt_s  = ST_FILL;
        wr_cnt_nxt_s = CNT_ZERO;
        rd_cnt_nxt_s = CNT_ZERO;
      end
    endcase
    in_ready_nxt_s = (state_nxt_s == ST_FILL);
    busy_nxt_s     = (state_nxt_s != ST_FILL);
  end

  // State, counters and registered handshake/framing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FILL;
      wr_cnt_r   <= CNT_ZERO;
      rd_cnt_r   <= CNT_ZERO;
      tx_valid_r <= 1'b0;
      tx_sof_r   <= 1'b0;
      tx_eof_r   <= 1'b0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
      csum_r     <= '0;
      csum_out_r <= '0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      wr_cnt_r   <= wr_cnt_nxt_s;
      rd_cnt_r   <= rd_cnt_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      tx_sof_r   <= tx_sof_nxt_s;
      tx_eof_r   <= tx_eof_nxt_s;
      in_ready_r <= in_ready_nxt_s;
      busy_r     <= busy_nxt_s;
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
      csum_r     <= csum_nxt_s;
      csum_out_r <= csum_out_nxt_s;
`endif
    end
  end

  // Buffer read data and checksum byte are never non-zero in the same
  // cycle, so the bus is a simple OR of the two registers.
`ifdef IMAGE_FRAME_TX_CHECKSUM_EN
  assign tx_data  = ram_q_s | csum_out_r;
`else
  assign tx_data  = ram_q_s;
`endif
  assign tx_valid = tx_valid_r;
  assign tx_sof   = tx_sof_r;
  assign tx_eof   = tx_eof_r;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_image_frame_tx.sv
// Self-checking bench for image_frame_tx (default build, 64 x 8-bit frames).
// Accepted pixels go into a scoreboard queue; transmitted bytes pop it.
module tb_image_frame_tx;

  localparam int FP = 64;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx_en;
  logic [PW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_sof;
  logic          tx_eof;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [PW-1:0] sb_q [$];

  image_frame_tx #(.FRAME_PIXELS(FP), .PIXEL_W(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_sof   (tx_sof),
    .tx_eof   (tx_eof),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'hA5;
      2:       return 8'(i * 3 + 1);
      default: return 8'(200 - i);
    endcase
  endfunction

  // Offer pixels until a full frame is accepted; inputs change on negedge.
  task automatic fill(input int mode, input bit toggle, input bit en_in_fill);
    int acc = 0;
    int cyc = 0;
    while (acc < FP && cyc < 1000) begin
      @(negedge clk);
      if (en_in_fill) begin
        chk("tx_idle_in_fill", {31'd0, tx_valid}, 32'd0);
      end
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = pix(mode, acc);
      tx_en    = en_in_fill;
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        acc++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tx_en    = 1'b0;
    chk("fill_accepts", acc, FP);
    if (toggle) begin
      chk("toggle_within_128", {31'd0, cyc <= 128}, 32'd1);
    end
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_tx_valid", {31'd0, tx_valid}, 32'd0);
  endtask

  // Pulse tx_en and check the whole burst; optionally reset at abort_idx.
  task automatic send(input int abort_idx, input bit wiggle);
    logic [PW-1:0] exp_d;
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    for (int idx = 0; idx < FP; idx++) begin
      chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
      chk($sformatf("tx_valid[%0d]", idx), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("tx_data[%0d]", idx), {24'd0, tx_data}, {24'd0, exp_d});
      chk($sformatf("tx_sof[%0d]", idx), {31'd0, tx_sof}, {31'd0, idx == 0});
      chk($sformatf("tx_eof[%0d]", idx), {31'd0, tx_eof}, {31'd0, idx == FP - 1});
      if (idx == abort_idx) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_tx_eof", {31'd0, tx_eof}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        chk("abort_quiet_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_quiet_eof", {31'd0, tx_eof}, 32'd0);
        return;
      end
      if (wiggle) begin
        tx_en = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    tx_en = 1'b0;
    chk("post_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("post_tx_eof", {31'd0, tx_eof}, 32'd0);
    chk("post_tx_data", {24'd0, tx_data}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tx_en    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_sof", {31'd0, tx_sof}, 32'd0);
    chk("rst_tx_eof", {31'd0, tx_eof}, 32'd0);

    // Frame of 0..63 with in_valid held high.
    fill(0, 1'b0, 1'b0);

    // Pixels offered while FULL must be ignored.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      chk("full_ignores_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_ignores_tx_valid", {31'd0, tx_valid}, 32'd0);
    end
    in_valid = 1'b0;
    send(-1, 1'b0);

    // Every-other-cycle A5 frame; tx_en wiggles during the burst.
    fill(1, 1'b1, 1'b0);
    send(-1, 1'b1);

    // tx_en high during FILL is ignored; reset on the 10th byte aborts.
    fill(2, 1'b0, 1'b1);
    send(9, 1'b0);

    // Next frame must start at address 0 after the abort.
    fill(3, 1'b0, 1'b0);
    send(-1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
